ladybird_reset_sequencer: RTL



---
 rtl/ladybird_config_pkg.sv | 32 +++
 rtl/ladybird_sync_cell.sv | 40 ++++
 rtl/ladybird_reset_sequencer.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/ladybird_config_pkg.sv
// ---------------------------------------------------------------------------
// ladybird_config
//   Shared configuration for the ladybird SoC top level: reset-sequencer
//   state encoding, reset-request source indices and small elaboration-time
//   helpers used to size the sequencer's counter.
// ---------------------------------------------------------------------------
package ladybird_config;

  // Reset sequencer states.
  typedef enum logic [1:0] {
    RST_RESET = 2'd0,
    RST_HOLD  = 2'd1,
    RST_WAKE  = 2'd2,
    RST_RUN   = 2'd3
  } rstseq_state_t;

  // Reset-request source indices at the SoC top level.
  localparam int RST_SRC_SWITCH = 0;
  localparam int RST_SRC_BUTTON = 1;
  localparam int N_RST_SRC      = 2;

  function automatic int rstseq_max(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // One counter serves both the hold time and the start delay, so it is
  // sized for the larger of the two load values.
  function automatic int rstseq_cnt_width(input int hold_cycles, input int start_delay);
    return $clog2(rstseq_max(hold_cycles, start_delay) + 1);
  endfunction

endpackage

// File: rtl/ladybird_sync_cell.sv
// ---------------------------------------------------------------------------
// ladybird_sync_cell
//   Multi-stage flop-chain synchroniser, one independent chain per bit.
//   All stages clear asynchronously when anrst_i is low; the output only
//   rises STAGES clock edges after anrst_i is released with d_i high.
//
// Ports:
//   clk_i    in   1      clock
//   anrst_i  in   1      asynchronous active-low clear of every stage
//   d_i      in   WIDTH  data to synchronise
//   q_o      out  WIDTH  synchronised data (last stage of each chain)
// ---------------------------------------------------------------------------
module ladybird_sync_cell #(
  parameter int WIDTH  = 1,
  parameter int STAGES = 2
) (
  input  logic             clk_i,
  input  logic             anrst_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_bit
      logic [STAGES-1:0] chain_q;

      always_ff @(posedge clk_i or negedge anrst_i) begin
        if (!anrst_i) begin
          chain_q <= '0;
        end else begin
          chain_q <= {chain_q[STAGES-2:0], d_i[gi]};
        end
      end

      assign q_o[gi] = chain_q[STAGES-1];
    end
  endgenerate

endmodule

// File: rtl/ladybird_reset_sequencer.sv
// ---------------------------------------------------------------------------
// ladybird_reset_sequencer
//   Reset / wake-up controller for the ladybird SoC. Sequences
//   RESET -> HOLD -> WAKE -> RUN, keeps nrst low for a programmable hold
//   time after power-on or after the last unmasked reset request, asserts
//   start a programmable delay after nrst rises (as a level or a pulse) and
//   records the cause of the most recent reset in a sticky register.
//
// Ports:
//   clk        in   1        system clock
//   anrst      in   1        asynchronous active-low power-on reset
//   rst_req    in   N_SRC    per-source reset request (level, clk domain)
//   rst_mask   in   N_SRC    1 = source ignored
//   cause_clr  in   1        clear cause; only acted on in RUN
//   nrst       out  1        registered active-low reset to the SoC
//   start      out  1        core wake-up
//   cause      out  N_SRC+1  bit0 = power-on, bit i+1 = rst_req[i]
//   busy       out  1        high whenever the sequencer is not in RUN
// ---------------------------------------------------------------------------
module ladybird_reset_sequencer
  import ladybird_config::*;
#(
  parameter int N_SRC       = N_RST_SRC,
  parameter int SYNC_STAGES = 2,
  parameter int HOLD_CYCLES = 16,
  parameter int START_DELAY = 1,
  parameter int START_LEVEL = 1
) (
  input  logic             clk,
  input  logic             anrst,
  input  logic [N_SRC-1:0] rst_req,
  input  logic [N_SRC-1:0] rst_mask,
  input  logic             cause_clr,
  output logic             nrst,
  output logic             start,
  output logic [N_SRC:0]   cause,
  output logic             busy
);

  localparam int                CNT_W      = rstseq_cnt_width(HOLD_CYCLES, START_DELAY);
  localparam logic [CNT_W-1:0]  HOLD_LOAD  = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0]  DELAY_LOAD = CNT_W'(START_DELAY - 1);
  localparam logic [N_SRC:0]    CAUSE_POR  = (N_SRC + 1)'(1);

  // -------------------------------------------------------------------------
  // anrst release path: the sequencer leaves RESET only once the release
  // has propagated through the synchroniser, so nrst deassertion is always
  // synchronous to clk even though assertion is immediate.
  // -------------------------------------------------------------------------
  logic sync_done;

  ladybird_sync_cell #(
    .WIDTH  (1),
    .STAGES (SYNC_STAGES)
  ) u_anrst_sync (
    .clk_i   (clk),
    .anrst_i (anrst),
    .d_i     (1'b1),
    .q_o     (sync_done)
  );

  // -------------------------------------------------------------------------
  // Request qualification: a masked source is invisible to the sequencer.
  // -------------------------------------------------------------------------
  logic [N_SRC-1:0] req_active;
  logic             any_req;

  genvar gi;
  generate
    for (gi = 0; gi < N_SRC; gi++) begin : g_src
      assign req_active[gi] = rst_req[gi] & ~rst_mask[gi];
    end
  endgenerate

  assign any_req = |req_active;

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  rstseq_state_t    state_q, state_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic [N_SRC:0]   cause_q, cause_d;
  logic             nrst_q,  nrst_d;
  logic             start_q, start_d;

  logic             cnt_zero;
  logic [CNT_W-1:0] cnt_dec;

  assign cnt_zero = (cnt_q == '0);
  // Saturating decrement: the counter never wraps below zero.
  assign cnt_dec  = cnt_zero ? '0 : (cnt_q - CNT_W'(1));

  // -------------------------------------------------------------------------
  // Next-state / output logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cause_d = cause_q;

    unique case (state_q)
      RST_RESET: begin
        if (sync_done) begin
          state_d = RST_HOLD;
          cnt_d   = HOLD_LOAD;
        end
      end

      RST_HOLD: begin
        // Requests seen while holding accumulate into the cause.
        cause_d = cause_q | {req_active, 1'b0};
        if (any_req) begin
          // The hold time restarts from every cycle a request is present.
          cnt_d = HOLD_LOAD;
        end else if (cnt_zero) begin
          state_d = RST_WAKE;
          cnt_d   = DELAY_LOAD;
        end else begin
          cnt_d = cnt_dec;
        end
      end

      RST_WAKE: begin
        if (any_req) begin
          state_d = RST_HOLD;
          cnt_d   = HOLD_LOAD;
          cause_d = {req_active, 1'b0};
        end else if (cnt_zero) begin
          state_d = RST_RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_dec;
        end
      end

      RST_RUN: begin
        // A new trigger replaces the cause and takes priority over a clear
        // arriving on the same edge.
        if (any_req) begin
          state_d = RST_HOLD;
          cnt_d   = HOLD_LOAD;
          cause_d = {req_active, 1'b0};
        end else if (cause_clr) begin
          cause_d = '0;
        end
      end

      default: begin
        state_d = RST_RESET;
        cnt_d   = '0;
      end
    endcase

    // Outputs are registered from the next state so that they change on the
    // same edge as the state transition that causes them.
    nrst_d  = (state_d == RST_WAKE) || (state_d == RST_RUN);
    start_d = (state_d == RST_RUN) &&
              ((START_LEVEL != 0) || (state_q != RST_RUN));
  end

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge anrst) begin
    if (!anrst) begin
      state_q <= RST_RESET;
      cnt_q   <= '0;
      cause_q <= CAUSE_POR;
      nrst_q  <= 1'b0;
      start_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cause_q <= cause_d;
      nrst_q  <= nrst_d;
      start_q <= start_d;
    end
  end

  assign nrst  = nrst_q;
  assign start = start_q;
  assign cause = cause_q;
  // Decoded from the state register so it follows anrst immediately.
  assign busy  = (state_q != RST_RUN);

endmodule
